// File: rtl/as_pack.sv
// Shared definitions for the rv64i debug port: TAP state encoding and IR width.
package as_pack;

    localparam int ir_width = 8;

    // Encoding follows the classic 1149.1 state codes so capture/shift pairs share bits.
    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PA_DR  = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PA_IR  = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

endpackage

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: state machine, IR/DR strobes and TDO mux.
// Optional JTAG_TDO_NEGEDGE_EN registers tdo/tdo_en on the falling edge of tck.
module jtag_tap_ctrl
    import as_pack::*;
(
    input  logic tck,
    input  logic trst_n,
    input  logic tms,
    input  logic ir_sero,
    input  logic dr_sero,
    output logic tlr,
    output logic ir_clock,
    output logic ir_shift,
    output logic ir_upd,
    output logic dr_clock,
    output logic dr_shift,
    output logic dr_upd,
    output logic tdo,
    output logic tdo_en
);

    tap_state_t state;
    tap_state_t state_nxt;
    logic       tdo_comb;
    logic       tdo_en_comb;

    always_comb begin
        state_nxt = state;
        unique case (state)
            TLR:    state_nxt = tms ? TLR    : RTI;
            RTI:    state_nxt = tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = tms ? UPD_DR : PA_DR;
            PA_DR:  state_nxt = tms ? EX2_DR : PA_DR;
            EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = tms ? SEL_DR : RTI;
            SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
            CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = tms ? UPD_IR : PA_IR;
            PA_IR:  state_nxt = tms ? EX2_IR : PA_IR;
            EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = tms ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture and shift codes differ only in bit 2, so each clock enable is one compare.
    assign tlr      = (state == TLR);
    assign ir_clock = ({state[3], state[1:0]} == 3'b110);
    assign ir_shift = (state == SH_IR);
    assign ir_upd   = (state == UPD_IR);
    assign dr_clock = ({state[3], state[1:0]} == 3'b010);
    assign dr_shift = (state == SH_DR);
    assign dr_upd   = (state == UPD_DR);

    // Only the shift states drive the pin, so the mux needs just the two shift decodes.
    assign tdo_en_comb = ir_shift | dr_shift;
    assign tdo_comb    = ir_shift ? ir_sero : (dr_shift ? dr_sero : 1'b0);

`ifdef JTAG_TDO_NEGEDGE_EN
    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo    <= tdo_comb;
            tdo_en <= tdo_en_comb;
        end
    end
`else
    assign tdo    = tdo_comb;
    assign tdo_en = tdo_en_comb;
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl with small behavioural IR and DR shift registers.
module tb_jtag_tap_ctrl;
    import as_pack::*;

    logic tck = 1'b0;
    logic trst_n = 1'b0;
    logic tms = 1'b1;
    logic ir_sero, dr_sero;
    logic tlr, ir_clock, ir_shift, ir_upd, dr_clock, dr_shift, dr_upd, tdo, tdo_en;

    int n_cmp = 0;
    int n_err = 0;

    logic [ir_width-1:0] ir_sr = '0;
    logic [7:0]          dr_sr = '0;

    always #5 tck = ~tck;

    jtag_tap_ctrl dut (
        .tck(tck), .trst_n(trst_n), .tms(tms),
        .ir_sero(ir_sero), .dr_sero(dr_sero),
        .tlr(tlr), .ir_clock(ir_clock), .ir_shift(ir_shift), .ir_upd(ir_upd),
        .dr_clock(dr_clock), .dr_shift(dr_shift), .dr_upd(dr_upd),
        .tdo(tdo), .tdo_en(tdo_en)
    );

    // Behavioural ir_reg / DR: capture a fixed value, shift right with tdi = 0.
    always @(posedge tck) begin
        if (ir_clock) ir_sr <= ir_shift ? {1'b0, ir_sr[ir_width-1:1]} : 8'had;
        if (dr_clock) dr_sr <= dr_shift ? {1'b0, dr_sr[7:1]} : 8'h3c;
    end
    assign ir_sero = ir_sr[0];
    assign dr_sero = dr_sr[0];

    // Outputs are sampled just after the falling edge so both TDO build options agree.
    task automatic step(input logic v);
        tms = v;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic test_reset;
        trst_n = 1'b0;
        tms = 1'b1;
        repeat (2) @(posedge tck);
        @(negedge tck); #1;
        n_cmp++;
        if ({tlr, ir_clock, ir_shift, ir_upd, dr_clock, dr_shift, dr_upd, tdo, tdo_en} !== 9'b1_0000_0000) begin
            n_err++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {tlr, ir_clock, ir_shift, ir_upd, dr_clock, dr_shift, dr_upd, tdo, tdo_en}, 9'b1_0000_0000);
        end
        trst_n = 1'b1;
        step(1'b1);
        n_cmp++;
        if (dut.state !== TLR || tlr !== 1'b1 || tdo_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release state=%h tlr=%b tdo_en=%b exp state=f tlr=1 tdo_en=0", dut.state, tlr, tdo_en);
        end
    endtask

    task automatic test_walk_ir;
        step(1'b0); step(1'b1); step(1'b1); step(1'b0);
        n_cmp++;
        if (dut.state !== CAP_IR || ir_clock !== 1'b1 || ir_shift !== 1'b0 || dr_clock !== 1'b0) begin
            n_err++;
            $display("FAIL cap_ir state=%h ir_clock=%b ir_shift=%b dr_clock=%b exp e/1/0/0",
                     dut.state, ir_clock, ir_shift, dr_clock);
        end
        tms = 1'b0;
        @(posedge tck); #1;
`ifdef JTAG_TDO_NEGEDGE_EN
        n_cmp++;
        if (tdo_en !== 1'b0) begin
            n_err++;
            $display("FAIL tdo_en_half_cycle_lag got=%b exp=0", tdo_en);
        end
`else
        n_cmp++;
        if (tdo_en !== 1'b1) begin
            n_err++;
            $display("FAIL tdo_en_comb got=%b exp=1", tdo_en);
        end
`endif
        @(negedge tck); #1;
        n_cmp++;
        if (dut.state !== SH_IR || ir_clock !== 1'b1 || ir_shift !== 1'b1 || tdo_en !== 1'b1) begin
            n_err++;
            $display("FAIL sh_ir_entry state=%h ir_clock=%b ir_shift=%b tdo_en=%b exp a/1/1/1",
                     dut.state, ir_clock, ir_shift, tdo_en);
        end
    endtask

    task automatic test_ir_shift;
        logic [7:0] exp_bits;
        int upd_cnt;
        exp_bits = 8'b1010_1101;
        upd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (tdo !== exp_bits[i] || tdo_en !== 1'b1) begin
                n_err++;
                $display("FAIL ir_tdo_bit%0d got=%b en=%b exp=%b en=1", i, tdo, tdo_en, exp_bits[i]);
            end
            step(i == 7);
        end
        n_cmp++;
        if (dut.state !== EX1_IR || tdo_en !== 1'b0 || tdo !== 1'b0) begin
            n_err++;
            $display("FAIL ex1_ir state=%h tdo=%b tdo_en=%b exp 9/0/0", dut.state, tdo, tdo_en);
        end
        for (int i = 0; i < 3; i++) begin
            upd_cnt += int'(ir_upd);
            step(i == 0);
        end
        n_cmp++;
        if (upd_cnt !== 1 || dut.state !== RTI) begin
            n_err++;
            $display("FAIL ir_upd_pulse count=%0d state=%h exp count=1 state=c", upd_cnt, dut.state);
        end
    endtask

    task automatic test_pause;
        step(1'b1); step(1'b0); step(1'b0);
        n_cmp++;
        if (dut.state !== SH_DR || dr_shift !== 1'b1 || dr_clock !== 1'b1 || tdo !== 1'b0) begin
            n_err++;
            $display("FAIL sh_dr_entry state=%h dr_shift=%b dr_clock=%b tdo=%b exp 2/1/1/0",
                     dut.state, dr_shift, dr_clock, tdo);
        end
        step(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            n_cmp++;
            if (dut.state !== PA_DR || dr_clock !== 1'b0 || tdo_en !== 1'b0) begin
                n_err++;
                $display("FAIL pause%0d state=%h dr_clock=%b tdo_en=%b exp 3/0/0", i, dut.state, dr_clock, tdo_en);
            end
        end
        step(1'b1); step(1'b0);
        n_cmp++;
        if (dut.state !== SH_DR || dr_shift !== 1'b1 || dr_sr !== 8'h1e || tdo !== 1'b0 || tdo_en !== 1'b1) begin
            n_err++;
            $display("FAIL pause_resume state=%h dr_shift=%b dr=%h tdo=%b en=%b exp 2/1/1e/0/1",
                     dut.state, dr_shift, dr_sr, tdo, tdo_en);
        end
        step(1'b0);
        n_cmp++;
        if (tdo !== 1'b1 || dr_sr !== 8'h0f) begin
            n_err++;
            $display("FAIL dr_shift_after_pause tdo=%b dr=%h exp tdo=1 dr=0f", tdo, dr_sr);
        end
    endtask

    task automatic test_recovery;
        step(1'b1); step(1'b1); step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        n_cmp++;
        if (dut.state !== SH_IR) begin
            n_err++;
            $display("FAIL recovery_setup state=%h exp=a", dut.state);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            n_cmp++;
            if (tlr !== (i == 4)) begin
                n_err++;
                $display("FAIL five_tms_edge%0d tlr=%b state=%h exp tlr=%b", i, tlr, dut.state, (i == 4));
            end
        end
        step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        n_cmp++;
        if (dr_shift !== 1'b1) begin
            n_err++;
            $display("FAIL trst_setup dr_shift=%b exp=1", dr_shift);
        end
        tms = 1'b0;
        @(posedge tck); #2;
        trst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut.state !== TLR || tlr !== 1'b1 || dr_shift !== 1'b0 || dr_clock !== 1'b0 || tdo_en !== 1'b0) begin
            n_err++;
            $display("FAIL trst_async state=%h tlr=%b dr_shift=%b dr_clock=%b tdo_en=%b exp f/1/0/0/0",
                     dut.state, tlr, dr_shift, dr_clock, tdo_en);
        end
        @(negedge tck); #1;
        trst_n = 1'b1;
        step(1'b0);
        n_cmp++;
        if (dut.state !== RTI || tlr !== 1'b0) begin
            n_err++;
            $display("FAIL trst_restart state=%h tlr=%b exp c/0", dut.state, tlr);
        end
    endtask

    initial begin
        test_reset();
        test_walk_ir();
        test_ir_shift();
        test_pause();
        test_recovery();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
